cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
Two-requester arbiter that shares the single Cache request port between the instruction-fetch side (I) and the load/store side (D).
- Latches the winning request and issues it to the Cache with a one-cycle is_input_valid pulse.
- Waits for the Cache response, then routes dout/is_hit back to the granted requester.
- Keeps saturating hit/miss statistics and a watchdog so a hung memory cannot stall the pipeline silently.

Parameters:
TIMEOUT_CYCLES, 256, WAIT-state cycles before the watchdog aborts the transaction
COUNT_W, 16, width of hit/miss statistic counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
i_req_valid  input  1  I-side request present
i_addr  input  32  I-side byte address
i_req_ready  output  1  I-side request accepted this cycle
i_resp_valid  output  1  I-side response pulse
d_req_valid  input  1  D-side request present
d_addr  input  32  D-side byte address
d_mem_read  input  1  D-side load
d_mem_write  input  1  D-side store
d_din  input  32  D-side store data
d_req_ready  output  1  D-side request accepted this cycle
d_resp_valid  output  1  D-side response pulse
resp_dout  output  32  response data, shared by both sides
resp_is_hit  output  1  Cache hit flag for the response
resp_timeout  output  1  response was produced by watchdog abort
cache_is_input_valid  output  1  to Cache is_input_valid
cache_addr  output  32  to Cache addr
cache_mem_read  output  1  to Cache mem_read
cache_mem_write  output  1  to Cache mem_write
cache_din  output  32  to Cache din
cache_is_ready  input  1  from Cache is_ready
cache_is_output_valid  input  1  from Cache is_output_valid
cache_dout  input  32  from Cache dout
cache_is_hit  input  1  from Cache is_hit
hit_count  output  COUNT_W  saturating count of completed hits
miss_count  output  COUNT_W  saturating count of completed misses

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; all outputs 0; latched request, watchdog and counters 0; round-robin pointer = D. Reset mid-transaction drops the in-flight request without issuing a response.
- I side is always a read: issued with mem_read=1, mem_write=0, din=0.
- D side with both mem_read and mem_write set: write wins, forwarded as mem_read=0, mem_write=1.
- D side with neither set: forwarded unchanged and completes normally.
- IDLE:
  - If cache_is_ready==1 and any *_req_valid==1, select a winner and pulse that side's *_req_ready (combinational, this cycle only).
  - Register the winner's addr/cmd/din and the grant identity; go ISSUE.
  - If cache_is_ready==0, no grant is made.
- ISSUE: cache_is_input_valid=1 for exactly one cycle with the latched fields; go WAIT. cache_addr/cmd/din are held stable from ISSUE through WAIT.
- WAIT:
  - Watchdog increments every cycle.
  - On the first cycle with cache_is_output_valid==1: register resp_dout=cache_dout and resp_is_hit=cache_is_hit; pulse the granted side's *_resp_valid next cycle; increment hit_count or miss_count (saturating at all-ones); clear watchdog; go IDLE.
  - If the watchdog reaches TIMEOUT_CYCLES first: pulse *_resp_valid with resp_timeout=1, resp_dout=0, resp_is_hit=0; no counter update; go IDLE.
- Latency: request accepted at cycle T, ISSUE at T+1, earliest response pulse at T+3 (cache responds at T+2). The next grant is possible in the cycle after the response pulse. Only one transaction is outstanding at any time.
- Arbitration (default): fixed priority, D over I. I may starve while D requests continuously.
- resp_dout/resp_is_hit/resp_timeout hold their values until the next response.
- Requests deasserted before they are granted are simply not taken; no sticky state.

Optional Feature:
ARB_ROUND_ROBIN_EN:
- Defined: when both sides request in the same IDLE cycle, grant the side opposite to the last grant; the pointer updates on every grant. Single requests are granted regardless of the pointer.
- Undefined: fixed D-over-I priority and no pointer logic.

Test Plan:
- D load to 0x0000_0010 only; cache returns output_valid at T+2 with dout=0xDEAD_BEEF, hit=1 -> d_req_ready at T; cache_is_input_valid only at T+1; d_resp_valid at T+3 with dout=0xDEAD_BEEF; hit_count=1.
- I and D valid in the same cycle (macro off), repeated 3 times -> D granted all 3 times; i_req_ready stays 0 while d_req_valid=1.
- Same stimulus with ARB_ROUND_ROBIN_EN -> grants alternate D, I, D; responses route to the matching *_resp_valid.
- D store with mem_read=mem_write=1, addr 0x40, din 0x1234 -> cache sees mem_write=1, mem_read=0, din=0x1234; miss response -> miss_count=1.
- Cache never asserts output_valid, TIMEOUT_CYCLES=8 -> resp_valid at ISSUE+9 with resp_timeout=1, dout=0; counters unchanged; next request accepted.
- reset driven to 0 during WAIT -> next cycle state IDLE, all outputs 0, no resp_valid for the dropped request; counters cleared.

Source files
------------

// File: rtl/cache_arbiter.sv
// Shares one Cache request port between the I-fetch and D load/store sides, with a watchdog
// and saturating hit/miss statistics. Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
`timescale 1ns/1ps
module cache_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned COUNT_W        = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_req_valid,
   input  logic [31:0]        i_addr,
   output logic               i_req_ready,
   output logic               i_resp_valid,
   input  logic               d_req_valid,
   input  logic [31:0]        d_addr,
   input  logic               d_mem_read,
   input  logic               d_mem_write,
   input  logic [31:0]        d_din,
   output logic               d_req_ready,
   output logic               d_resp_valid,
   output logic [31:0]        resp_dout,
   output logic               resp_is_hit,
   output logic               resp_timeout,
   output logic               cache_is_input_valid,
   output logic [31:0]        cache_addr,
   output logic               cache_mem_read,
   output logic               cache_mem_write,
   output logic [31:0]        cache_din,
   input  logic               cache_is_ready,
   input  logic               cache_is_output_valid,
   input  logic [31:0]        cache_dout,
   input  logic               cache_is_hit,
   output logic [COUNT_W-1:0] hit_count,
   output logic [COUNT_W-1:0] miss_count
);

   localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;
   localparam logic [1:0] StResp  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic               grant_d_q;
   logic [31:0]        addr_q, din_q;
   logic               rd_q, wr_q;
   logic [WdW-1:0]     wd_q;
   logic [31:0]        dout_q;
   logic               hit_q, timeout_q;
   logic [COUNT_W-1:0] hit_cnt_q, miss_cnt_q;

   logic grant_any, pick_d, wait_done, wait_abort;

`ifdef ARB_ROUND_ROBIN_EN
   // Side preferred on the next contested grant; starts at D.
   logic prefer_d_q;
   assign pick_d = d_req_valid & (~i_req_valid | prefer_d_q);
`else
   assign pick_d = d_req_valid;
`endif

   assign grant_any = reset & (state_q == StIdle) & cache_is_ready & (i_req_valid | d_req_valid);
   assign d_req_ready = grant_any & pick_d;
   assign i_req_ready = grant_any & ~pick_d;

   // A response on the last allowed WAIT cycle still wins over the abort.
   assign wait_done  = (state_q == StWait) & cache_is_output_valid;
   assign wait_abort = (state_q == StWait) & ~cache_is_output_valid &
                       (wd_q == WdW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (grant_any) state_d = StIssue;
         StIssue: state_d = StWait;
         StWait:  if (wait_done || wait_abort) state_d = StResp;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StIdle;
         grant_d_q  <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         wd_q       <= '0;
         dout_q     <= '0;
         hit_q      <= 1'b0;
         timeout_q  <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (grant_any) begin
            grant_d_q <= pick_d;
            addr_q    <= pick_d ? d_addr : i_addr;
            rd_q      <= pick_d ? (d_mem_read & ~d_mem_write) : 1'b1;
            wr_q      <= pick_d & d_mem_write;
            din_q     <= pick_d ? d_din : '0;
         end
         if (state_q == StWait && !wait_done && !wait_abort) wd_q <= wd_q + 1'b1;
         else wd_q <= '0;
         if (wait_done) begin
            dout_q    <= cache_dout;
            hit_q     <= cache_is_hit;
            timeout_q <= 1'b0;
            if (cache_is_hit) begin
               if (~&hit_cnt_q) hit_cnt_q <= hit_cnt_q + 1'b1;
            end else begin
               if (~&miss_cnt_q) miss_cnt_q <= miss_cnt_q + 1'b1;
            end
         end else if (wait_abort) begin
            dout_q    <= '0;
            hit_q     <= 1'b0;
            timeout_q <= 1'b1;
         end
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (!reset) prefer_d_q <= 1'b1;
      else if (grant_any) prefer_d_q <= ~pick_d;
   end
`endif

   assign cache_is_input_valid = (state_q == StIssue);
   assign cache_addr           = addr_q;
   assign cache_mem_read       = rd_q;
   assign cache_mem_write      = wr_q;
   assign cache_din            = din_q;
   assign i_resp_valid         = (state_q == StResp) & ~grant_d_q;
   assign d_resp_valid         = (state_q == StResp) & grant_d_q;
   assign resp_dout            = dout_q;
   assign resp_is_hit          = hit_q;
   assign resp_timeout         = timeout_q;
   assign hit_count            = hit_cnt_q;
   assign miss_count           = miss_cnt_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter (small watchdog and 2-bit counters).
`timescale 1ns/1ps
module tb_cache_arbiter;

   localparam int unsigned TimeoutCycles = 8;
   localparam int unsigned CountW        = 2;
   localparam int unsigned CntMax        = (1 << CountW) - 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              i_req_valid, i_req_ready, i_resp_valid;
   logic [31:0]       i_addr;
   logic              d_req_valid, d_mem_read, d_mem_write, d_req_ready, d_resp_valid;
   logic [31:0]       d_addr, d_din;
   logic [31:0]       resp_dout;
   logic              resp_is_hit, resp_timeout;
   logic              cache_is_input_valid, cache_mem_read, cache_mem_write;
   logic [31:0]       cache_addr, cache_din;
   logic              cache_is_ready, cache_is_output_valid, cache_is_hit;
   logic [31:0]       cache_dout;
   logic [CountW-1:0] hit_count, miss_count;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_hits = 0;
   int exp_miss = 0;

   always #5 clk = ~clk;

   cache_arbiter #(
      .TIMEOUT_CYCLES(TimeoutCycles),
      .COUNT_W       (CountW)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .i_req_valid          (i_req_valid),
      .i_addr               (i_addr),
      .i_req_ready          (i_req_ready),
      .i_resp_valid         (i_resp_valid),
      .d_req_valid          (d_req_valid),
      .d_addr               (d_addr),
      .d_mem_read           (d_mem_read),
      .d_mem_write          (d_mem_write),
      .d_din                (d_din),
      .d_req_ready          (d_req_ready),
      .d_resp_valid         (d_resp_valid),
      .resp_dout            (resp_dout),
      .resp_is_hit          (resp_is_hit),
      .resp_timeout         (resp_timeout),
      .cache_is_input_valid (cache_is_input_valid),
      .cache_addr           (cache_addr),
      .cache_mem_read       (cache_mem_read),
      .cache_mem_write      (cache_mem_write),
      .cache_din            (cache_din),
      .cache_is_ready       (cache_is_ready),
      .cache_is_output_valid(cache_is_output_valid),
      .cache_dout           (cache_dout),
      .cache_is_hit         (cache_is_hit),
      .hit_count            (hit_count),
      .miss_count           (miss_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // One full transaction: accept at T, ISSUE at T+1, cache answers at T+2, response at T+3.
   task automatic do_txn(input string tag, input bit iv, input bit dv, input logic [31:0] ia,
                         input logic [31:0] da, input bit drd, input bit dwr,
                         input logic [31:0] ddin, input bit exp_d, input logic [31:0] rdata,
                         input bit hit);
      logic [31:0] e_addr, e_din;
      bit          e_rd, e_wr;
      e_addr = exp_d ? da : ia;
      e_din  = exp_d ? ddin : 32'h0;
      e_rd   = exp_d ? (drd & ~dwr) : 1'b1;
      e_wr   = exp_d ? dwr : 1'b0;
      @(negedge clk);
      i_req_valid = iv; i_addr = ia;
      d_req_valid = dv; d_addr = da; d_mem_read = drd; d_mem_write = dwr; d_din = ddin;
      cache_is_ready = 1'b1;
      #1;
      check({tag, ".d_ready"}, 32'(d_req_ready), 32'(exp_d));
      check({tag, ".i_ready"}, 32'(i_req_ready), 32'(!exp_d));
      @(negedge clk);
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      #1;
      check({tag, ".issue"}, 32'(cache_is_input_valid), 32'd1);
      check({tag, ".addr"}, cache_addr, e_addr);
      check({tag, ".rd"}, 32'(cache_mem_read), 32'(e_rd));
      check({tag, ".wr"}, 32'(cache_mem_write), 32'(e_wr));
      check({tag, ".din"}, cache_din, e_din);
      @(negedge clk);
      cache_is_output_valid = 1'b1; cache_dout = rdata; cache_is_hit = hit;
      #1;
      check({tag, ".issue_once"}, 32'(cache_is_input_valid), 32'd0);
      check({tag, ".addr_hold"}, cache_addr, e_addr);
      check({tag, ".no_early_resp"}, 32'(d_resp_valid | i_resp_valid), 32'd0);
      @(negedge clk);
      cache_is_output_valid = 1'b0; cache_dout = 32'h0; cache_is_hit = 1'b0;
      if (hit) begin
         if (exp_hits < CntMax) exp_hits++;
      end else begin
         if (exp_miss < CntMax) exp_miss++;
      end
      #1;
      check({tag, ".d_resp"}, 32'(d_resp_valid), 32'(exp_d));
      check({tag, ".i_resp"}, 32'(i_resp_valid), 32'(!exp_d));
      check({tag, ".dout"}, resp_dout, rdata);
      check({tag, ".hit"}, 32'(resp_is_hit), 32'(hit));
      check({tag, ".timeout"}, 32'(resp_timeout), 32'd0);
      check({tag, ".hits"}, 32'(hit_count), 32'(exp_hits));
      check({tag, ".misses"}, 32'(miss_count), 32'(exp_miss));
   endtask

   initial begin
      bit exp_d;
      reset = 1'b0;
      i_req_valid = 1'b0; i_addr = 32'h0;
      d_req_valid = 1'b0; d_addr = 32'h0; d_mem_read = 1'b0; d_mem_write = 1'b0; d_din = 32'h0;
      cache_is_ready = 1'b1; cache_is_output_valid = 1'b0; cache_dout = 32'h0;
      cache_is_hit = 1'b0;

      // Reset state, including no grant while reset is held
      repeat (2) @(negedge clk);
      d_req_valid = 1'b1; d_mem_read = 1'b1;
      #1;
      check("rst.d_ready", 32'(d_req_ready), 32'd0);
      check("rst.issue", 32'(cache_is_input_valid), 32'd0);
      check("rst.resp", 32'(d_resp_valid | i_resp_valid), 32'd0);
      check("rst.addr", cache_addr, 32'h0);
      check("rst.dout", resp_dout, 32'h0);
      check("rst.hits", 32'(hit_count), 32'd0);
      check("rst.misses", 32'(miss_count), 32'd0);
      @(negedge clk);
      reset = 1'b1; d_req_valid = 1'b0;

      // Cache busy: no grant
      @(negedge clk);
      d_req_valid = 1'b1; d_mem_read = 1'b1; d_addr = 32'h10; cache_is_ready = 1'b0;
      #1;
      check("busy.d_ready", 32'(d_req_ready), 32'd0);
      @(negedge clk);
      d_req_valid = 1'b0; cache_is_ready = 1'b1;
      #1;
      check("busy.no_issue", 32'(cache_is_input_valid), 32'd0);

      do_txn("dload", 0, 1, 32'h0, 32'h10, 1, 0, 32'h0, 1, 32'hDEAD_BEEF, 1);
      do_txn("dstore", 0, 1, 32'h0, 32'h40, 1, 1, 32'h1234, 1, 32'hCAFE_0000, 0);
      do_txn("dnone", 0, 1, 32'h0, 32'h44, 0, 0, 32'h55, 1, 32'h0BAD_F00D, 1);
      do_txn("ifetch", 1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 0, 32'h1111_2222, 1);

      // Reset during WAIT drops the transaction and clears everything
      @(negedge clk);
      d_req_valid = 1'b1; d_mem_read = 1'b1; d_mem_write = 1'b0; d_addr = 32'h80;
      @(negedge clk);
      d_req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      exp_hits = 0; exp_miss = 0;
      #1;
      check("rstwait.resp", 32'(d_resp_valid | i_resp_valid), 32'd0);
      check("rstwait.issue", 32'(cache_is_input_valid), 32'd0);
      check("rstwait.addr", cache_addr, 32'h0);
      check("rstwait.dout", resp_dout, 32'h0);
      check("rstwait.hits", 32'(hit_count), 32'd0);
      check("rstwait.misses", 32'(miss_count), 32'd0);
      @(negedge clk);
      #1;
      check("rstwait.resp2", 32'(d_resp_valid | i_resp_valid), 32'd0);

      // Contested requests; third hit reaches the 2-bit counter ceiling
      for (int k = 0; k < 3; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
         exp_d = (k != 1);
`else
         exp_d = 1'b1;
`endif
         do_txn($sformatf("arb%0d", k), 1, 1, 32'h200 + 32'(k * 4), 32'h300 + 32'(k * 4),
                1, 0, 32'h0, exp_d, 32'hA0 + 32'(k), 1);
      end

      // Watchdog abort: response at ISSUE+9
      @(negedge clk);
      d_req_valid = 1'b1; d_mem_read = 1'b1; d_mem_write = 1'b0; d_addr = 32'h500;
      i_req_valid = 1'b0;
      #1;
      check("to.d_ready", 32'(d_req_ready), 32'd1);
      @(negedge clk);
      d_req_valid = 1'b0;
      #1;
      check("to.issue", 32'(cache_is_input_valid), 32'd1);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         #1;
         check($sformatf("to.wait%0d", c), 32'(d_resp_valid), 32'd0);
      end
      @(negedge clk);
      #1;
      check("to.d_resp", 32'(d_resp_valid), 32'd1);
      check("to.flag", 32'(resp_timeout), 32'd1);
      check("to.dout", resp_dout, 32'h0);
      check("to.hit", 32'(resp_is_hit), 32'd0);
      check("to.hits", 32'(hit_count), 32'(exp_hits));
      check("to.misses", 32'(miss_count), 32'(exp_miss));

      // Next request accepted; hit counter must stay saturated
      do_txn("after_to", 0, 1, 32'h0, 32'h600, 1, 0, 32'h0, 1, 32'h7777_8888, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
